// File: rtl/sc_spil_pkg.sv
// Shared types and constants for the SPI Lite transaction arbiter.
package sc_spil_pkg;

  localparam int SPL_ARB_MAXREQ = 8;
  localparam int SPL_CS_W       = 5;
  localparam int SPL_DW_W       = 9;
  localparam int SPL_DATA_W     = 32;
  localparam int SPL_TMO_W      = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } SPL_ARB_ST_e;

  // Round-robin successor of idx over n slots.
  function automatic int spl_arb_next_idx(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/sc_spil_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module sc_spil_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the pointer, wrapping; only the first hit is granted.
  always_comb begin
    logic found;
    logic hit;
    int   j;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j        = (int'(ptr_i) + i) % N;
      hit      = req_i[j] & ~found;
      gnt_o[j] = hit;
      idx_o    = hit ? IW'(j) : idx_o;
      found    = found | hit;
    end
  end

endmodule

// File: rtl/sc_spil_arb.sv
// Round-robin arbiter/sequencer sharing one SPI Lite core among several
// requesters, with chip-select-locked bursts and a lock release watchdog.
module sc_spil_arb
  import sc_spil_pkg::*;
#(
  parameter int NUM_OF_REQ   = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                    SYSCLK,
  input  logic                    SYSRSTB,
  input  logic [NUM_OF_REQ-1:0]   REQ,
  input  logic [NUM_OF_REQ-1:0]   REQ_LOCK,
  input  logic [5*NUM_OF_REQ-1:0] REQ_CS,
  input  logic [9*NUM_OF_REQ-1:0] REQ_DWIDTH,
  input  logic [32*NUM_OF_REQ-1:0] REQ_TXDATA,
  output logic [NUM_OF_REQ-1:0]   GNT,
  output logic [NUM_OF_REQ-1:0]   ACK,
  output logic [31:0]             RDATA,
  output logic [4:0]              CSSEL,
  output logic                    CSEXTEND,
  output logic [8:0]              DWIDTH,
  output logic [31:0]             TXDATA,
  output logic                    TXSTART,
  input  logic                    SPIBUSY,
  input  logic                    SPICOMPLETE,
  input  logic [31:0]             RXDATA
);

  localparam int IW = $clog2(NUM_OF_REQ);

  SPL_ARB_ST_e               st_q;
  logic [IW-1:0]             ptr_q;
  logic [IW-1:0]             ptr_d;
  logic [IW-1:0]             owner_q;
  logic [NUM_OF_REQ-1:0]     gnt_q;
  logic [NUM_OF_REQ-1:0]     ack_q;
  logic [SPL_DATA_W-1:0]     rdata_q;
  logic [SPL_CS_W-1:0]       cssel_q;
  logic                      csext_q;
  logic [SPL_DW_W-1:0]       dwidth_q;
  logic [SPL_DATA_W-1:0]     txdata_q;
  logic                      txstart_q;
  logic [SPL_TMO_W-1:0]      tmo_q;

  logic [NUM_OF_REQ-1:0]     pick_s;
  logic [IW-1:0]             win_s;
  logic [IW-1:0]             sel_s;
  logic [SPL_CS_W-1:0]       pl_cs_s;
  logic [SPL_DW_W-1:0]       pl_dw_s;
  logic [SPL_DATA_W-1:0]     pl_tx_s;
  logic                      pl_lock_s;
  logic                      tmo_hit_s;

  sc_spil_rr_pick #(
    .N  (NUM_OF_REQ),
    .IW (IW)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_s),
    .idx_o (win_s)
  );

  // In HOLD only the locked owner may reload; otherwise the picker's winner.
  assign sel_s     = (st_q == HOLD) ? owner_q : win_s;
  assign pl_cs_s   = REQ_CS[int'(sel_s)*SPL_CS_W +: SPL_CS_W];
  assign pl_dw_s   = REQ_DWIDTH[int'(sel_s)*SPL_DW_W +: SPL_DW_W];
  assign pl_tx_s   = REQ_TXDATA[int'(sel_s)*SPL_DATA_W +: SPL_DATA_W];
  assign pl_lock_s = REQ_LOCK[sel_s];
  assign ptr_d     = IW'(spl_arb_next_idx(int'(owner_q), NUM_OF_REQ));
  assign tmo_hit_s = ((tmo_q + 16'd1) == 16'(LOCK_TIMEOUT));

  // Arbitration/sequencing FSM with registered core-side and requester outputs.
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      st_q      <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      cssel_q   <= '0;
      csext_q   <= 1'b0;
      dwidth_q  <= '0;
      txdata_q  <= '0;
      txstart_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      ack_q <= '0;
      case (st_q)
        IDLE: begin
          if (|REQ) begin
            gnt_q     <= pick_s;
            owner_q   <= win_s;
            cssel_q   <= pl_cs_s;
            dwidth_q  <= pl_dw_s;
            txdata_q  <= pl_tx_s;
            csext_q   <= pl_lock_s;
            txstart_q <= 1'b1;
            st_q      <= START;
          end
        end
        START: begin
          // A completion without any busy phase still finishes the frame.
          if (SPICOMPLETE) begin
            txstart_q <= 1'b0;
            rdata_q   <= RXDATA;
            ack_q     <= gnt_q;
            st_q      <= DONE;
          end else if (SPIBUSY) begin
            txstart_q <= 1'b0;
            st_q      <= BUSY;
          end
        end
        BUSY: begin
          if (SPICOMPLETE) begin
            rdata_q <= RXDATA;
            ack_q   <= gnt_q;
            st_q    <= DONE;
          end
        end
        DONE: begin
          tmo_q <= '0;
          if (csext_q) begin
            st_q <= HOLD;
          end else begin
            gnt_q <= '0;
            ptr_q <= ptr_d;
            st_q  <= IDLE;
          end
        end
        HOLD: begin
          // Owner re-request takes priority over a coincident timeout.
          if (REQ[owner_q]) begin
            cssel_q   <= pl_cs_s;
            dwidth_q  <= pl_dw_s;
            txdata_q  <= pl_tx_s;
            csext_q   <= pl_lock_s;
            txstart_q <= 1'b1;
            tmo_q     <= '0;
            st_q      <= START;
          end else if (!REQ_LOCK[owner_q] || tmo_hit_s) begin
            gnt_q   <= '0;
            csext_q <= 1'b0;
            ptr_q   <= ptr_d;
            tmo_q   <= '0;
            st_q    <= IDLE;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: begin
          gnt_q     <= '0;
          csext_q   <= 1'b0;
          txstart_q <= 1'b0;
          tmo_q     <= '0;
          st_q      <= IDLE;
        end
      endcase
    end
  end

  assign GNT      = gnt_q;
  assign ACK      = ack_q;
  assign RDATA    = rdata_q;
  assign CSSEL    = cssel_q;
  assign CSEXTEND = csext_q;
  assign DWIDTH   = dwidth_q;
  assign TXDATA   = txdata_q;
  assign TXSTART  = txstart_q;

endmodule

// File: tb/tb_sc_spil_arb.sv
// Directed bench for sc_spil_arb: a simple SPI core model plus an ACK scoreboard.
module tb_sc_spil_arb;

  localparam int NR = 4;

  logic           SYSCLK;
  logic           SYSRSTB;
  logic [NR-1:0]  REQ;
  logic [NR-1:0]  REQ_LOCK;
  logic [5*NR-1:0]  REQ_CS;
  logic [9*NR-1:0]  REQ_DWIDTH;
  logic [32*NR-1:0] REQ_TXDATA;
  logic [NR-1:0]  GNT;
  logic [NR-1:0]  ACK;
  logic [31:0]    RDATA;
  logic [4:0]     CSSEL;
  logic           CSEXTEND;
  logic [8:0]     DWIDTH;
  logic [31:0]    TXDATA;
  logic           TXSTART;
  logic           SPIBUSY;
  logic           SPICOMPLETE;
  logic [31:0]    RXDATA;

  typedef struct {
    logic [NR-1:0] ack;
    logic [31:0]   rdata;
  } sb_t;

  sb_t sb_q[$];
  int  total;
  int  bad;
  bit  ack_seen;
  bit  fast_mode;
  bit  stall_mode;

  sc_spil_arb #(
    .NUM_OF_REQ   (NR),
    .LOCK_TIMEOUT (16)
  ) dut (
    .SYSCLK      (SYSCLK),
    .SYSRSTB     (SYSRSTB),
    .REQ         (REQ),
    .REQ_LOCK    (REQ_LOCK),
    .REQ_CS      (REQ_CS),
    .REQ_DWIDTH  (REQ_DWIDTH),
    .REQ_TXDATA  (REQ_TXDATA),
    .GNT         (GNT),
    .ACK         (ACK),
    .RDATA       (RDATA),
    .CSSEL       (CSSEL),
    .CSEXTEND    (CSEXTEND),
    .DWIDTH      (DWIDTH),
    .TXDATA      (TXDATA),
    .TXSTART     (TXSTART),
    .SPIBUSY     (SPIBUSY),
    .SPICOMPLETE (SPICOMPLETE),
    .RXDATA      (RXDATA)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  function automatic logic [31:0] rx_fn(input logic [31:0] x);
    return x ^ 32'h0000_00FF;
  endfunction

  // Core model: busy for a few cycles then a completion pulse; fast mode
  // completes straight from START, stall mode never completes.
  initial begin : core_model
    int          cnt;
    logic [31:0] tx_lat;
    cnt         = 0;
    tx_lat      = 32'h0;
    SPIBUSY     = 1'b0;
    SPICOMPLETE = 1'b0;
    RXDATA      = 32'h0;
    forever begin
      @(negedge SYSCLK);
      SPICOMPLETE = 1'b0;
      if (!SYSRSTB) begin
        SPIBUSY = 1'b0;
        cnt     = 0;
      end else if (cnt == 0) begin
        if (TXSTART) begin
          tx_lat = TXDATA;
          if (fast_mode) begin
            RXDATA      = rx_fn(tx_lat);
            SPICOMPLETE = 1'b1;
          end else begin
            SPIBUSY = 1'b1;
            cnt     = stall_mode ? 1000000 : 3;
          end
        end
      end else begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          SPIBUSY     = 1'b0;
          RXDATA      = rx_fn(tx_lat);
          SPICOMPLETE = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] tx);
    sb_t e;
    e.ack   = 4'b0001 << idx;
    e.rdata = rx_fn(tx);
    sb_q.push_back(e);
  endtask

  task automatic set_pl(input int i, input logic [4:0] cs, input logic [8:0] dw,
                        input logic [31:0] tx, input logic lk);
    REQ_CS[i*5 +: 5]      = cs;
    REQ_DWIDTH[i*9 +: 9]  = dw;
    REQ_TXDATA[i*32 +: 32] = tx;
    REQ_LOCK[i]           = lk;
  endtask

  // Advance one cycle; any ACK is checked against the scoreboard head.
  task automatic tick();
    sb_t e;
    @(negedge SYSCLK);
    ack_seen = (ACK !== 4'b0000);
    if (ack_seen) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL ack_unexpected observed=%0h expected=none", ACK);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ack_owner", 64'(ACK), 64'(e.ack));
        chk("rdata", 64'(RDATA), 64'(e.rdata));
        chk("gnt_at_ack", 64'(GNT), 64'(e.ack));
      end
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    tick();
    while (!ack_seen && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(ack_seen), 64'd1);
  endtask

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin : main
    int order[6];
    int n;
    logic [31:0] tx;
    order = '{1, 2, 3, 0, 1, 2};
    total = 0;
    bad = 0;
    ack_seen = 1'b0;
    fast_mode = 1'b0;
    stall_mode = 1'b0;
    SYSRSTB = 1'b0;
    REQ = '0;
    REQ_LOCK = '0;
    REQ_CS = '0;
    REQ_DWIDTH = '0;
    REQ_TXDATA = '0;
    repeat (3) tick();
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_ack", 64'(ACK), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_txstart", 64'(TXSTART), 64'd0);
    chk("rst_csext", 64'(CSEXTEND), 64'd0);
    chk("rst_cssel", 64'(CSSEL), 64'd0);
    chk("rst_dwidth", 64'(DWIDTH), 64'd0);
    chk("rst_txdata", 64'(TXDATA), 64'd0);
    SYSRSTB = 1'b1;
    tick();

    // Single frame from requester 0
    set_pl(0, 5'd3, 9'd8, 32'h0000_00A5, 1'b0);
    push(0, 32'h0000_00A5);
    REQ = 4'b0001;
    tick();
    chk("t1_gnt", 64'(GNT), 64'h1);
    chk("t1_cssel", 64'(CSSEL), 64'd3);
    chk("t1_dwidth", 64'(DWIDTH), 64'd8);
    chk("t1_txdata", 64'(TXDATA), 64'hA5);
    chk("t1_txstart", 64'(TXSTART), 64'd1);
    chk("t1_csext", 64'(CSEXTEND), 64'd0);
    wait_ack("t1_ack");
    REQ = 4'b0000;
    tick();
    chk("t1_ack_pulse", 64'(ACK), 64'd0);
    chk("t1_rdata_hold", 64'(RDATA), 64'h5A);

    // All four requesting; pointer starts at 1 after requester 0 was served
    for (int i = 0; i < NR; i++) begin
      set_pl(i, 5'(i + 1), 9'(8 * (i + 1)), 32'h1000_0000 + 32'(i * 32'h0101_0101), 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      push(order[k], 32'h1000_0000 + 32'(order[k] * 32'h0101_0101));
    end
    REQ = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ack("rr_ack");
      chk("rr_cssel", 64'(CSSEL), 64'(order[k] + 1));
      if (k == 5) REQ = 4'b0000;
    end
    tick();

    // Locked burst of three frames from requester 2 while requester 1 waits
    set_pl(2, 5'd7, 9'd32, 32'hC0DE_0000, 1'b1);
    set_pl(1, 5'd2, 9'd8, 32'h1111_2222, 1'b0);
    push(2, 32'hC0DE_0000);
    REQ = 4'b0100;
    tick();
    chk("lk_gnt_first", 64'(GNT), 64'h4);
    chk("lk_csext_first", 64'(CSEXTEND), 64'd1);
    REQ = 4'b0110;
    for (int f = 0; f < 3; f++) begin
      wait_ack("lk_ack");
      chk("lk_csext", 64'(CSEXTEND), 64'd1);
      chk("lk_gnt", 64'(GNT), 64'h4);
      if (f < 2) begin
        tx = 32'hC0DE_0000 + 32'(f + 1);
        REQ_TXDATA[2*32 +: 32] = tx;
        push(2, tx);
      end else begin
        REQ = 4'b0010;
        REQ_LOCK[2] = 1'b0;
        push(1, 32'h1111_2222);
      end
    end
    wait_ack("lk_r1_ack");
    chk("lk_r1_csext", 64'(CSEXTEND), 64'd0);
    REQ = 4'b0000;
    tick();

    // Lock held with no re-request: watchdog releases after 16 HOLD cycles
    set_pl(2, 5'd9, 9'd16, 32'hBEEF_0001, 1'b1);
    set_pl(3, 5'd4, 9'd24, 32'h3333_4444, 1'b0);
    push(2, 32'hBEEF_0001);
    REQ = 4'b0100;
    wait_ack("to_ack");
    REQ = 4'b1000;
    push(3, 32'h3333_4444);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (CSEXTEND) n++;
      else break;
    end
    chk("to_hold_cycles", 64'(n), 64'd16);
    chk("to_gnt_released", 64'(GNT), 64'd0);
    tick();
    chk("to_gnt3", 64'(GNT), 64'h8);
    wait_ack("to_r3_ack");
    REQ = 4'b0000;
    REQ_LOCK[2] = 1'b0;
    tick();

    // Completion while still in START (no busy phase)
    fast_mode = 1'b1;
    set_pl(0, 5'd1, 9'd32, 32'h1234_5678, 1'b0);
    push(0, 32'h1234_5678);
    REQ = 4'b0001;
    tick();
    chk("fs_txstart", 64'(TXSTART), 64'd1);
    wait_ack("fs_ack");
    REQ = 4'b0000;
    fast_mode = 1'b0;
    tick();

    // Reset during BUSY aborts the frame; pointer restarts at 0
    stall_mode = 1'b1;
    set_pl(1, 5'd6, 9'd8, 32'hDEAD_0001, 1'b1);
    REQ = 4'b0010;
    repeat (4) tick();
    chk("rs_pre_gnt", 64'(GNT), 64'h2);
    chk("rs_pre_csext", 64'(CSEXTEND), 64'd1);
    #2;
    SYSRSTB = 1'b0;
    #1;
    chk("rs_txstart", 64'(TXSTART), 64'd0);
    chk("rs_csext", 64'(CSEXTEND), 64'd0);
    chk("rs_gnt", 64'(GNT), 64'd0);
    REQ = 4'b0000;
    REQ_LOCK = 4'b0000;
    stall_mode = 1'b0;
    repeat (2) tick();
    SYSRSTB = 1'b1;
    tick();
    set_pl(0, 5'd2, 9'd8, 32'h0F0F_0F0F, 1'b0);
    set_pl(1, 5'd6, 9'd8, 32'hDEAD_0002, 1'b0);
    push(0, 32'h0F0F_0F0F);
    REQ = 4'b0011;
    tick();
    chk("rs_post_gnt", 64'(GNT), 64'h1);
    wait_ack("rs_post_ack");
    REQ = 4'b0000;
    repeat (3) tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_spil_arb.md
# sc_spil_arb

Round-robin transaction arbiter and sequencer in front of the SPI Lite core's transaction interface. It lets several hardware requesters share one SPI Lite core, for example a flash-boot fetcher, a sensor poller and a housekeeping engine. For each granted request it drives chip-select, frame width and TX data, starts the transfer, waits for completion and returns the received word. It also supports chip-select-locked multi-frame bursts with a release watchdog. It sits between the requesters and the core-side ports that `sc_spil_reg` otherwise drives; one of the two owns the core at a time, selected by a top-level mux outside this block.

## Interface
Parameters:
- NUM_OF_REQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 255, SYSCLK cycles a locked grant waits for the next request before forced release (1..65535).

Ports:
- SYSCLK  in  1  system clock.
- SYSRSTB  in  1  reset; asynchronous, active-low. Clock SYSCLK.
- REQ  in  NUM_OF_REQ  per-requester transaction request, level.
- REQ_LOCK  in  NUM_OF_REQ  keep CS asserted and keep the grant after this frame.
- REQ_CS  in  5*NUM_OF_REQ  chip-select index per requester.
- REQ_DWIDTH  in  9*NUM_OF_REQ  frame size per requester.
- REQ_TXDATA  in  32*NUM_OF_REQ  TX word per requester.
- GNT  out  NUM_OF_REQ  one-hot current owner.
- ACK  out  NUM_OF_REQ  one-cycle completion pulse.
- RDATA  out  32  received word; valid while any ACK bit is high.
- CSSEL  out  5  to core.
- CSEXTEND  out  1  to core.
- DWIDTH  out  9  to core.
- TXDATA  out  32  to core.
- TXSTART  out  1  to core.
- SPIBUSY  in  1  from core.
- SPICOMPLETE  in  1  from core; one-cycle pulse.
- RXDATA  in  32  from core; stable from SPICOMPLETE until the next TXSTART.

## Operation
- FSM states: IDLE, START, BUSY, DONE, HOLD.
- IDLE
  - When |REQ is high, pick a winner with round-robin priority, starting at the index after the last grantee.
  - Register the winner in GNT and latch its REQ_CS, REQ_DWIDTH, REQ_TXDATA and REQ_LOCK into the core outputs.
  - Next state: START.
- START
  - TXSTART=1.
  - On SPIBUSY go to BUSY; TXSTART=0 from the next cycle.
  - SPICOMPLETE in START, without SPIBUSY having been seen, counts as completion: go directly to DONE.
- BUSY
  - Wait for SPICOMPLETE, capture RXDATA into RDATA, go to DONE.
- DONE
  - ACK[owner]=1 for one cycle.
  - If the latched lock bit is set, go to HOLD with CSEXTEND kept at 1.
  - Otherwise clear GNT and CSEXTEND, and advance the round-robin pointer to owner+1 mod NUM_OF_REQ. Next state: IDLE.
- HOLD
  - Only the owner may be served; other requesters wait.
  - Owner REQ=1: relatch its payload, reset the timeout counter, go to START.
  - Owner REQ_LOCK=0 with REQ=0: release. GNT=0, CSEXTEND=0, pointer advances, go to IDLE.
  - Timeout counter reaches LOCK_TIMEOUT: same release.
- CSEXTEND equals the latched lock bit while the owner's transfer is in progress.
- Requesters must hold REQ and payload stable until their ACK.
  - A REQ drop mid-transfer is ignored; the frame completes and ACK still pulses.
  - REQ held high after ACK is a new request.
- Round-robin pointer width is clog2(NUM_OF_REQ). Wrap from NUM_OF_REQ-1 to 0.

## Timing
- Reset value of every output is 0, including RDATA and GNT. FSM resets to IDLE, round-robin pointer to 0, timeout counter to 0.
- Reset asserted mid-transfer clears TXSTART and CSEXTEND immediately (asynchronously). No ACK is issued for the aborted frame.
- REQ rising at cycle 0 in IDLE: GNT and core outputs at cycle 1, TXSTART=1 from cycle 1.
- ACK is at the cycle after SPICOMPLETE. RDATA updates in that same cycle and holds until the next capture.
- Back-to-back without lock: the next grant comes at the earliest 1 cycle after ACK (the IDLE cycle).
- Locked re-request: TXSTART at the cycle after REQ is seen in HOLD.
- Timeout: release occurs when the counter reaches LOCK_TIMEOUT cycles spent in HOLD without owner REQ.
- Simultaneous owner REQ and timeout expiry in the same cycle: REQ wins, and the counter resets.

## Structure
- sc_spil_pkg gains:
  - typedef enum SPL_ARB_ST_e {IDLE, START, BUSY, DONE, HOLD}.
  - Constant SPL_ARB_MAXREQ = 8.
- Sub-module sc_spil_rr_pick: purely combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and winner index.
  - Reusable by other Space Cubics arbiters.
- Top level holds the FSM, payload latches, timeout counter and RDATA register.

## Test plan
- REQ=4'b0001, CS=3, DWIDTH=8, TXDATA=0xA5: CSSEL=3 and TXSTART at cycle 1. Model SPICOMPLETE with RXDATA=0x5A → ACK[0]=1 and RDATA=0x5A the next cycle.
- REQ=4'b1111 held continuously: grants go 0,1,2,3,0 with exactly one ACK each, and the order is unchanged after pointer wrap.
- Requester 2 with REQ_LOCK=1 for three frames while requester 1 also requests: CSEXTEND stays 1 across all three frames, and GNT[1] only after requester 2 drops lock.
- Lock held with owner REQ=0, LOCK_TIMEOUT=16: release after 16 HOLD cycles, CSEXTEND falls, requester 3 is granted next.
- SYSRSTB pulsed low during BUSY: TXSTART, CSEXTEND and GNT are 0 immediately, no ACK is issued, and a new request after reset is granted starting from requester 0.
- SPICOMPLETE arriving while still in START (SPIBUSY never high): ACK is still issued, and RDATA is captured correctly.
